// File: rtl/dram_burst_scheduler.sv
// Frame read sequencer: splits a frame into AXI-legal DRAM read bursts (length- and
// 4 KB-limited), paces them on reader idle and FIFO credit, and tracks returned beats.
module dram_burst_scheduler #(
  parameter int DRAM_ADDR_WIDTH  = 39,
  parameter int DRAM_DATA_WIDTH  = 128,
  parameter int MAX_BURST_LEN    = 256,
  parameter int BOUNDARY_BYTES   = 4096,
  parameter int BEAT_COUNT_WIDTH = 20,
  parameter int BUFFER_CREDIT    = 2000
) (
  input  logic                        clk_pixel,
  input  logic                        image_sender_resetn,
  input  logic                        frame_start,
  input  logic [DRAM_ADDR_WIDTH-1:0]  frame_addr,
  input  logic [BEAT_COUNT_WIDTH-1:0] frame_beats,
  input  logic                        frame_abort,
  output logic                        frame_busy,
  output logic                        frame_done,
  output logic                        frame_aborted,
  output logic [DRAM_ADDR_WIDTH-1:0]  dram_read_addr,
  output logic [7:0]                  dram_read_len,
  output logic                        dram_read_en,
  input  logic                        dram_read_busy,
  input  logic                        dram_buffer_full,
  input  logic                        dram_read_data_valid,
  input  logic                        buffer_beat_consumed,
  output logic [BEAT_COUNT_WIDTH-1:0] beats_received
);

  localparam int AW             = DRAM_ADDR_WIDTH;
  localparam int BW             = BEAT_COUNT_WIDTH;
  localparam int BYTES_PER_BEAT = DRAM_DATA_WIDTH / 8;
  localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
  localparam int BOUND_SHIFT    = $clog2(BOUNDARY_BYTES);
  localparam int BOUND_BEATS    = BOUNDARY_BYTES / BYTES_PER_BEAT;

  localparam logic [BW-1:0] MAX_BURST  = BW'(MAX_BURST_LEN);
  localparam logic [BW-1:0] BOUND_MAX  = BW'(BOUND_BEATS);
  localparam logic [BW:0]   CREDIT_MAX = (BW+1)'(BUFFER_CREDIT);
  localparam logic [AW-1:0] BEAT_MASK  = ~AW'(BYTES_PER_BEAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_HOLD, S_DRAIN} state_t;

  // Reset asserts asynchronously but releases synchronously to clk_pixel.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_pixel or negedge image_sender_resetn) begin
    if (!image_sender_resetn) rst_sync_q <= 2'b00;
    else                      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_t          state_q, state_d;
  logic [AW-1:0]   cur_addr_q, cur_addr_d;
  logic [BW-1:0]   remaining_q, remaining_d;
  logic [BW-1:0]   issued_q, issued_d;
  logic [BW-1:0]   recv_q, recv_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [BW-1:0]   credit_q, credit_d;
  logic            aborted_q, aborted_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            aborted_out_q, aborted_out_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [7:0]      rd_len_q, rd_len_d;

  logic [BW-1:0]   to_bound;
  logic [BW-1:0]   burst_c;
  logic [BW:0]     credit_c;
  logic            issue;

  // Beats left before the next boundary; cur_addr is always beat-aligned.
  assign to_bound = BOUND_MAX - BW'(cur_addr_q[BOUND_SHIFT-1:BEAT_SHIFT]);

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    issued_d      = issued_q;
    recv_d        = recv_q;
    burst_d       = burst_q;
    aborted_d     = aborted_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    aborted_out_d = 1'b0;
    rd_addr_d     = rd_addr_q;
    rd_len_d      = rd_len_q;
    issue         = 1'b0;

    burst_c = remaining_q;
    if (MAX_BURST < burst_c) burst_c = MAX_BURST;
    if (to_bound < burst_c)  burst_c = to_bound;

    if (busy_q && dram_read_data_valid && (recv_q != issued_q)) recv_d = recv_q + BW'(1);

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          cur_addr_d  = frame_addr & BEAT_MASK;
          remaining_d = frame_beats;
          issued_d    = '0;
          recv_d      = '0;
          aborted_d   = 1'b0;
          busy_d      = 1'b1;
          state_d     = (frame_beats == '0) ? S_DRAIN : S_CALC;
        end
      end
      S_CALC: begin
        burst_d   = burst_c;
        rd_addr_d = cur_addr_q;
        rd_len_d  = 8'(burst_c - BW'(1));
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        if (frame_abort) begin
          aborted_d = 1'b1;
          state_d   = S_DRAIN;
        end else if (!dram_read_busy && !dram_buffer_full && (credit_q >= burst_q)) begin
          issue       = 1'b1;
          cur_addr_d  = cur_addr_q + (AW'(burst_q) << BEAT_SHIFT);
          remaining_d = remaining_q - burst_q;
          issued_d    = issued_q + burst_q;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if ((remaining_q == '0) || frame_abort) begin
          aborted_d = (remaining_q != '0);
          state_d   = S_DRAIN;
        end else begin
          state_d = S_CALC;
        end
      end
      S_DRAIN: begin
        if (recv_q == issued_q) begin
          done_d        = 1'b1;
          aborted_out_d = aborted_q;
          busy_d        = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Issue never underflows: it is gated on credit_q >= burst_q.
    credit_c = {1'b0, credit_q} + (BW+1)'(buffer_beat_consumed);
    if (issue) credit_c = credit_c - {1'b0, burst_q};
    if (credit_c > CREDIT_MAX) credit_c = CREDIT_MAX;
    credit_d = credit_c[BW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      issued_q      <= '0;
      recv_q        <= '0;
      burst_q       <= '0;
      credit_q      <= BW'(BUFFER_CREDIT);
      aborted_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_out_q <= 1'b0;
      rd_addr_q     <= '0;
      rd_len_q      <= '0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      issued_q      <= issued_d;
      recv_q        <= recv_d;
      burst_q       <= burst_d;
      credit_q      <= credit_d;
      aborted_q     <= aborted_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_out_q <= aborted_out_d;
      rd_addr_q     <= rd_addr_d;
      rd_len_q      <= rd_len_d;
    end
  end

  // The request pulse is combinational so it lands in the very cycle the gate opens.
  assign dram_read_en   = issue;
  assign dram_read_addr = rd_addr_q;
  assign dram_read_len  = rd_len_q;
  assign frame_busy     = busy_q;
  assign frame_done     = done_q;
  assign frame_aborted  = aborted_out_q;
  assign beats_received = recv_q;

endmodule

// File: tb/tb_dram_burst_scheduler.sv
// Bench for dram_burst_scheduler: a behavioural DRAM reader / FIFO consumer drives the
// handshake, and expected bursts and frame completions are queued and popped as they appear.
module tb_dram_burst_scheduler;

  localparam int AW = 39;
  localparam int BW = 20;

  logic          clk_pixel = 1'b0;
  logic          image_sender_resetn = 1'b1;
  logic          frame_start = 1'b0;
  logic [AW-1:0] frame_addr = '0;
  logic [BW-1:0] frame_beats = '0;
  logic          frame_abort = 1'b0;
  logic          frame_busy, frame_done, frame_aborted;
  logic [AW-1:0] dram_read_addr;
  logic [7:0]    dram_read_len;
  logic          dram_read_en;
  logic          dram_read_busy;
  logic          dram_buffer_full = 1'b0;
  logic          dram_read_data_valid = 1'b0;
  logic          buffer_beat_consumed = 1'b0;
  logic [BW-1:0] beats_received;

  always #5 clk_pixel = ~clk_pixel;

  dram_burst_scheduler dut (
    .clk_pixel(clk_pixel), .image_sender_resetn(image_sender_resetn),
    .frame_start(frame_start), .frame_addr(frame_addr), .frame_beats(frame_beats),
    .frame_abort(frame_abort), .frame_busy(frame_busy), .frame_done(frame_done),
    .frame_aborted(frame_aborted), .dram_read_addr(dram_read_addr),
    .dram_read_len(dram_read_len), .dram_read_en(dram_read_en),
    .dram_read_busy(dram_read_busy), .dram_buffer_full(dram_buffer_full),
    .dram_read_data_valid(dram_read_data_valid),
    .buffer_beat_consumed(buffer_beat_consumed), .beats_received(beats_received)
  );

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } burst_t;
  typedef struct { logic aborted; logic [BW-1:0] beats; } done_t;

  burst_t exp_bursts[$];
  done_t  exp_done[$];
  int total = 0;
  int bad = 0;
  int en_count = 0;
  int done_count = 0;

  // Reader / consumer model state
  int   rd_left = 0;
  int   buf_cnt = 0;
  int   manual_left = 0;
  bit   reader_return = 1'b1;
  bit   consume_on = 1'b1;
  bit   force_busy = 1'b0;
  logic model_busy = 1'b0;
  logic en_s;
  logic [7:0] len_s;

  assign dram_read_busy = model_busy | force_busy;

  always @(posedge clk_pixel) begin
    en_s  = dram_read_en;
    len_s = dram_read_len;
    #1;
    if (!image_sender_resetn) begin
      rd_left = 0; buf_cnt = 0; model_busy = 1'b0;
      dram_read_data_valid = 1'b0; buffer_beat_consumed = 1'b0;
    end else begin
      if (reader_return && rd_left > 0) begin
        dram_read_data_valid = 1'b1; rd_left--; buf_cnt++;
      end else begin
        dram_read_data_valid = 1'b0;
      end
      if (en_s === 1'b1) rd_left += int'(len_s) + 1;
      model_busy = (rd_left > 0);
      if (consume_on && buf_cnt > 0) begin
        buffer_beat_consumed = 1'b1; buf_cnt--;
      end else if (manual_left > 0) begin
        buffer_beat_consumed = 1'b1; manual_left--;
        if (buf_cnt > 0) buf_cnt--;
      end else begin
        buffer_beat_consumed = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every burst request and every frame_done is matched against the queues.
  always @(negedge clk_pixel) begin
    burst_t b;
    done_t  d;
    if (image_sender_resetn && dram_read_en === 1'b1) begin
      en_count++;
      total++;
      if (exp_bursts.size() == 0) begin
        bad++;
        $display("FAIL burst_unexpected: got addr=%h len=%0d, required no burst", dram_read_addr, dram_read_len);
      end else begin
        b = exp_bursts.pop_front();
        if (dram_read_addr !== b.addr || dram_read_len !== b.len) begin
          bad++;
          $display("FAIL burst: got addr=%h len=%0d, required addr=%h len=%0d",
                   dram_read_addr, dram_read_len, b.addr, b.len);
        end
      end
    end
    if (frame_done === 1'b1) begin
      done_count++;
      total++;
      if (exp_done.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected: got frame_done with beats=%0d, required none", beats_received);
      end else begin
        d = exp_done.pop_front();
        if (frame_aborted !== d.aborted || beats_received !== d.beats || frame_busy !== 1'b0) begin
          bad++;
          $display("FAIL done: got aborted=%b beats=%0d busy=%b, required aborted=%b beats=%0d busy=0",
                   frame_aborted, beats_received, frame_busy, d.aborted, d.beats);
        end
      end
    end
  end

  task automatic push_burst(input logic [AW-1:0] addr, input logic [7:0] len);
    burst_t b;
    b.addr = addr; b.len = len;
    exp_bursts.push_back(b);
  endtask

  task automatic push_done(input logic aborted, input logic [BW-1:0] beats);
    done_t d;
    d.aborted = aborted; d.beats = beats;
    exp_done.push_back(d);
  endtask

  task automatic start_frame(input logic [AW-1:0] addr, input logic [BW-1:0] beats);
    @(posedge clk_pixel); #1;
    frame_start = 1'b1; frame_addr = addr; frame_beats = beats;
    @(posedge clk_pixel); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int budget, output bit ok);
    int n = 0;
    while (done_count == prev && n < budget) begin
      @(negedge clk_pixel); n++;
    end
    @(negedge clk_pixel);
    ok = (done_count != prev);
  endtask

  task automatic wait_drained();
    int n = 0;
    while ((buf_cnt > 0 || rd_left > 0) && n < 4000) begin
      @(negedge clk_pixel); n++;
    end
  endtask

  task automatic test_reset();
    #1 image_sender_resetn = 1'b0;
    repeat (3) @(negedge clk_pixel);
    total++;
    if ({dram_read_addr, dram_read_len, dram_read_en, frame_busy, frame_done, frame_aborted, beats_received} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got addr=%h len=%0d en=%b busy=%b done=%b ab=%b rcv=%0d, required all 0",
               dram_read_addr, dram_read_len, dram_read_en, frame_busy, frame_done, frame_aborted, beats_received);
    end
    @(posedge clk_pixel); #1 image_sender_resetn = 1'b1;
    repeat (4) @(posedge clk_pixel);
  endtask

  task automatic test_basic();
    int prev = done_count;
    bit ok;
    push_burst('h0, 8'd255); push_burst('h1000, 8'd255); push_burst('h2000, 8'd112);
    push_done(1'b0, 20'd625);
    start_frame('h0, 20'd625);
    @(negedge clk_pixel);
    total++;
    if (frame_busy !== 1'b1) begin
      bad++; $display("FAIL basic_busy: got %b, required 1", frame_busy);
    end
    // A start pulse while busy must be ignored.
    repeat (3) @(posedge clk_pixel); #1;
    frame_start = 1'b1; frame_addr = 'h5000; frame_beats = 20'd7;
    @(posedge clk_pixel); #1 frame_start = 1'b0;
    wait_done(prev, 3000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_timeout: got no frame_done, required one"); end
    total++;
    if (exp_bursts.size() != 0) begin
      bad++; $display("FAIL basic_leftover: got %0d bursts missing, required 0", exp_bursts.size());
    end
  endtask

  task automatic test_boundary();
    int prev = done_count;
    bit ok;
    logic [AW-1:0] top;
    push_burst('hF80, 8'd7); push_burst('h1000, 8'd11);
    push_done(1'b0, 20'd20);
    start_frame('hF8C, 20'd20);  // low address bits are ignored
    wait_done(prev, 500, ok);
    total++;
    if (!ok || exp_bursts.size() != 0) begin
      bad++; $display("FAIL boundary: got done=%b left=%0d, required done=1 left=0", ok, exp_bursts.size());
    end
    // Two beats below the top of the address space, then wrap to 0.
    top = '1;
    top = top - AW'('h1F);
    prev = done_count;
    push_burst(top, 8'd1); push_burst('h0, 8'd1);
    push_done(1'b0, 20'd4);
    start_frame(top, 20'd4);
    wait_done(prev, 500, ok);
    total++;
    if (!ok || exp_bursts.size() != 0) begin
      bad++; $display("FAIL wrap: got done=%b left=%0d, required done=1 left=0", ok, exp_bursts.size());
    end
  endtask

  task automatic test_busy_stall();
    int prev = done_count;
    int base = en_count;
    bit ok;
    force_busy = 1'b1;
    push_burst('h40, 8'd15);
    push_done(1'b0, 20'd16);
    start_frame('h40, 20'd16);
    repeat (50) @(negedge clk_pixel);
    total++;
    if (en_count != base) begin
      bad++; $display("FAIL busy_hold: got %0d pulses, required 0", en_count - base);
    end
    @(posedge clk_pixel); #1 force_busy = 1'b0;
    @(negedge clk_pixel);
    total++;
    if (dram_read_en !== 1'b1) begin
      bad++; $display("FAIL busy_release: got en=%b, required 1", dram_read_en);
    end
    wait_done(prev, 500, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL busy_timeout: got no frame_done, required one"); end
  endtask

  task automatic test_abort();
    int prev = done_count;
    int n = 0;
    bit ok;
    push_burst('h0, 8'd255);
    push_done(1'b1, 20'd256);
    start_frame('h0, 20'd625);
    while (beats_received < 20'd100 && n < 600) begin
      @(negedge clk_pixel); n++;
    end
    total++;
    if (beats_received < 20'd100) begin
      bad++; $display("FAIL abort_wait: got rcv=%0d, required >=100", beats_received);
    end
    @(posedge clk_pixel); #1 frame_abort = 1'b1;
    wait_done(prev, 1000, ok);
    frame_abort = 1'b0;
    total++;
    if (!ok || exp_bursts.size() != 0) begin
      bad++; $display("FAIL abort: got done=%b left=%0d, required done=1 left=0", ok, exp_bursts.size());
    end
  endtask

  task automatic test_credit();
    int prev;
    int base;
    int n = 0;
    bit ok;
    wait_drained();
    consume_on = 1'b0;
    prev = done_count;
    base = en_count;
    for (int i = 0; i < 8; i++) push_burst(AW'(i) << 12, 8'd255);
    push_burst('h8000, 8'd51);
    push_done(1'b0, 20'd2100);
    start_frame('h0, 20'd2100);
    while (!((en_count - base) == 7 && rd_left == 0) && n < 3000) begin
      @(negedge clk_pixel); n++;
    end
    repeat (20) @(negedge clk_pixel);
    total++;
    if (en_count - base != 7) begin
      bad++; $display("FAIL credit_stall: got %0d bursts, required 7", en_count - base);
    end
    manual_left = 47;
    n = 0;
    while (manual_left > 0 && n < 200) begin @(negedge clk_pixel); n++; end
    repeat (5) @(negedge clk_pixel);
    total++;
    if (en_count - base != 7) begin
      bad++; $display("FAIL credit_short: got %0d bursts, required 7", en_count - base);
    end
    manual_left = 1;
    n = 0;
    while ((en_count - base) < 8 && n < 10) begin @(negedge clk_pixel); n++; end
    total++;
    if (en_count - base != 8) begin
      bad++; $display("FAIL credit_release: got %0d bursts, required 8", en_count - base);
    end
    consume_on = 1'b1;
    wait_done(prev, 6000, ok);
    total++;
    if (!ok || exp_bursts.size() != 0) begin
      bad++; $display("FAIL credit_done: got done=%b left=%0d, required done=1 left=0", ok, exp_bursts.size());
    end
  endtask

  task automatic test_mid_reset();
    int prev;
    int n;
    bit ok;
    wait_drained();
    reader_return = 1'b0;
    push_burst('h0, 8'd15);
    start_frame('h0, 20'd16);
    repeat (10) @(negedge clk_pixel);
    #2 image_sender_resetn = 1'b0;
    #1;
    total++;
    if ({dram_read_addr, dram_read_len, dram_read_en, frame_busy, frame_done, frame_aborted, beats_received} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got addr=%h len=%0d en=%b busy=%b done=%b ab=%b rcv=%0d, required all 0",
               dram_read_addr, dram_read_len, dram_read_en, frame_busy, frame_done, frame_aborted, beats_received);
    end
    repeat (3) @(posedge clk_pixel);
    #1 image_sender_resetn = 1'b1;
    reader_return = 1'b1;
    repeat (4) @(posedge clk_pixel);
    prev = done_count;
    push_done(1'b0, 20'd0);
    start_frame('h100, 20'd0);
    n = 0;
    while (frame_done !== 1'b1 && n < 3) begin @(negedge clk_pixel); n++; end
    total++;
    if (frame_done !== 1'b1) begin
      bad++; $display("FAIL zero_beats: got no frame_done within 3 cycles, required one");
    end
    @(negedge clk_pixel);
    prev = done_count;
    push_burst('h200, 8'd7);
    push_done(1'b0, 20'd8);
    start_frame('h200, 20'd8);
    wait_done(prev, 500, ok);
    total++;
    if (!ok || exp_bursts.size() != 0 || exp_done.size() != 0) begin
      bad++; $display("FAIL post_reset: got done=%b left=%0d/%0d, required done=1 left=0/0",
                      ok, exp_bursts.size(), exp_done.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_busy_stall();
    test_abort();
    test_credit();
    test_mid_reset();
    repeat (5) @(negedge clk_pixel);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_burst_scheduler.md
Name: dram_burst_scheduler

Overview:
- Sequences DRAM reads for one image frame on behalf of the image sender.
- Takes a start address and a total beat count, and splits the transfer into AXI-legal bursts: at most MAX_BURST_LEN beats, never crossing a 4 KB boundary.
- Issues each burst on the dram_read_* interface only when the DRAM reader is idle and the image data save FIFO has credit.
- Tracks returned beats and signals frame completion. Sits between the image address FIFO and the DRAM reader, on clk_pixel.

Parameters:
- DRAM_ADDR_WIDTH, 39, byte address width.
- DRAM_DATA_WIDTH, 128, beat width in bits; bytes per beat = DRAM_DATA_WIDTH/8 = 16.
- MAX_BURST_LEN, 256, maximum beats per burst (1..256).
- BOUNDARY_BYTES, 4096, bursts must not cross this address boundary.
- BEAT_COUNT_WIDTH, 20, width of frame beat counters.
- BUFFER_CREDIT, 2000, beats the data save FIFO can hold.

Ports:
- clk_pixel, in, 1, clock.
- image_sender_resetn, in, 1, asynchronous active-low reset.
- frame_start, in, 1, one-cycle pulse; accepted only in IDLE.
- frame_addr, in, DRAM_ADDR_WIDTH, first byte address; low 4 bits ignored (forced 0).
- frame_beats, in, BEAT_COUNT_WIDTH, total beats for the frame.
- frame_abort, in, 1, level; stop issuing new bursts.
- frame_busy, out, 1, high from accepted start until done.
- frame_done, out, 1, one-cycle completion pulse.
- frame_aborted, out, 1, valid with frame_done; 1 if the frame ended by abort.
- dram_read_addr, out, DRAM_ADDR_WIDTH, burst start address.
- dram_read_len, out, 8, burst beats minus 1.
- dram_read_en, out, 1, one-cycle burst request pulse.
- dram_read_busy, in, 1, DRAM reader busy.
- dram_buffer_full, in, 1, data save FIFO prog_full.
- dram_read_data_valid, in, 1, one returned beat.
- buffer_beat_consumed, in, 1, one beat popped from the data save FIFO.
- beats_received, out, BEAT_COUNT_WIDTH, beats returned this frame.

Behaviour:
- Reset (async assert, sync deassert internally):
  - State IDLE.
  - All outputs 0: dram_read_addr=0, dram_read_len=0, dram_read_en=0, frame_busy=0, frame_done=0, frame_aborted=0, beats_received=0.
  - Credit = BUFFER_CREDIT.
- States: IDLE, CALC, ISSUE, HOLD, DRAIN.
- IDLE:
  - On frame_start, latch cur_addr={frame_addr[hi:4],4'b0}, remaining=frame_beats, issued=0, beats_received=0, aborted=0.
  - Set frame_busy=1 next cycle, then go to CALC.
  - frame_beats=0 goes directly to DRAIN.
- CALC (1 cycle):
  - to_bound = (BOUNDARY_BYTES - cur_addr mod BOUNDARY_BYTES)/16.
  - burst = min(remaining, MAX_BURST_LEN, to_bound).
  - Register dram_read_addr=cur_addr and dram_read_len=burst-1. Go to ISSUE.
- ISSUE:
  - Pulse dram_read_en=1 for exactly one cycle in the first cycle where all of these hold: !dram_read_busy, !dram_buffer_full, credit >= burst.
  - In that same cycle: cur_addr += burst*16, remaining -= burst, issued += burst, credit -= burst. Go to HOLD.
  - If frame_abort=1 while waiting, go to DRAIN without issuing; aborted=1.
- HOLD (1 cycle): absorbs dram_read_busy assertion latency. If remaining=0 or frame_abort=1, go to DRAIN (set aborted if remaining≠0); else go to CALC.
- DRAIN:
  - When beats_received == issued, pulse frame_done=1 with frame_aborted=aborted.
  - frame_busy=0 in that same cycle. Go to IDLE.
- beats_received increments on every dram_read_data_valid while frame_busy. It saturates at issued; extra beats are ignored.
- Credit:
  - Increments on buffer_beat_consumed.
  - Decrements by burst on issue.
  - A simultaneous consume and issue nets to credit + 1 - burst.
  - Saturates at BUFFER_CREDIT.
  - Credit persists across frames; it is reset only by image_sender_resetn.
- frame_start outside IDLE is ignored.
- Address arithmetic wraps modulo 2^DRAM_ADDR_WIDTH.
- Reset mid-frame discards all state immediately. No frame_done is generated.

Test Plan:
- addr=0x0, beats=625, no backpressure → 3 bursts: (0x0, len 255), (0x1000, len 255), (0x2000, len 112). frame_done when beats_received=625.
- addr=0xF80, beats=20 → bursts (0xF80, len 7), (0x1000, len 11). No burst crosses 0x1000.
- dram_read_busy held high 50 cycles during ISSUE → dram_read_en stays 0. Pulse occurs the first cycle after busy drops.
- BUFFER_CREDIT=300, beats=625, no consume → only first burst (256) issues and scheduler stalls. After 212 consume pulses the second burst issues.
- frame_abort asserted after first burst with 100 beats returned → no further en. frame_done when 256 received, frame_aborted=1.
- Reset asserted mid-DRAIN → all outputs 0 asynchronously. A new frame_start after release runs normally; frame_beats=0 yields frame_done ≤3 cycles after start.
